// File: rtl/ball_step_gen_if.sv
// Button-request / step-pulse bundle for ball_step_gen.
// The slave side is the step generator; the master side drives the buttons.
interface ball_step_gen_if;
    logic       enable;
    logic       btn_xinc;
    logic       btn_xdec;
    logic       btn_yinc;
    logic       btn_ydec;
    logic       x_increment;
    logic       x_decrement;
    logic       y_increment;
    logic       y_decrement;
    logic [1:0] repeating;

    modport slave (
        input  enable,
        input  btn_xinc,
        input  btn_xdec,
        input  btn_yinc,
        input  btn_ydec,
        output x_increment,
        output x_decrement,
        output y_increment,
        output y_decrement,
        output repeating
    );

    modport master (
        output enable,
        output btn_xinc,
        output btn_xdec,
        output btn_yinc,
        output btn_ydec,
        input  x_increment,
        input  x_decrement,
        input  y_increment,
        input  y_decrement,
        input  repeating
    );
endinterface

// File: rtl/ball_step_gen.sv
// Ball step generator: one step pulse per press, then auto-repeat while held.
// Axis 0 is x, axis 1 is y; both axes run the same independent FSM.
module ball_step_gen #(
    parameter int SIMULATE      = 0,
    parameter int DELAY_CYCLES  = 50_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic           clk,
    input  logic           reset,
    ball_step_gen_if.slave bus
);
    localparam int DLY = (SIMULATE != 0) ? 10 : DELAY_CYCLES;
    localparam int RPT = (SIMULATE != 0) ? 4 : REPEAT_CYCLES;
    localparam logic [25:0] DLY_M1 = 26'(DLY - 1);
    localparam logic [25:0] RPT_M1 = 26'(RPT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    state_t      state_q [2];
    state_t      state_d [2];
    logic [25:0] cnt_q   [2];
    logic [25:0] cnt_d   [2];

    logic [1:0] dir_q;
    logic [1:0] dir_d;
    logic [1:0] inc_q;
    logic [1:0] dec_q;
    logic [1:0] inc_d;
    logic [1:0] dec_d;
    logic [1:0] pulse;
    logic [1:0] req;
    logic [1:0] req_dir;

    // Per-axis request: exactly one direction held and stepping enabled.
    always_comb begin
        req[0]     = bus.enable & (bus.btn_xinc ^ bus.btn_xdec);
        req[1]     = bus.enable & (bus.btn_yinc ^ bus.btn_ydec);
        req_dir[0] = bus.btn_xinc;
        req_dir[1] = bus.btn_yinc;
    end

    // Next state, counter and pulse for each axis.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        dir_d = dir_q;
        pulse = 2'b00;
        for (int i = 0; i < 2; i++) begin
            unique case (state_q[i])
                IDLE: begin
                    if (req[i]) begin
                        pulse[i]   = 1'b1;
                        state_d[i] = DELAY;
                        cnt_d[i]   = DLY_M1;
                        dir_d[i]   = req_dir[i];
                    end
                end
                DELAY, REPEAT: begin
                    if (!req[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (req_dir[i] != dir_q[i]) begin
                        // Reversal while held restarts as a fresh press.
                        pulse[i]   = 1'b1;
                        state_d[i] = DELAY;
                        cnt_d[i]   = DLY_M1;
                        dir_d[i]   = req_dir[i];
                    end else if (cnt_q[i] == '0) begin
                        pulse[i]   = 1'b1;
                        state_d[i] = REPEAT;
                        cnt_d[i]   = RPT_M1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 26'd1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        inc_d = pulse & dir_d;
        dec_d = pulse & ~dir_d;
    end

    // State, counter, direction and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            dir_q <= 2'b00;
            inc_q <= 2'b00;
            dec_q <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            dir_q <= dir_d;
            inc_q <= inc_d;
            dec_q <= dec_d;
        end
    end

    assign bus.x_increment  = inc_q[0];
    assign bus.x_decrement  = dec_q[0];
    assign bus.y_increment  = inc_q[1];
    assign bus.y_decrement  = dec_q[1];
    assign bus.repeating[0] = (state_q[0] == REPEAT);
    assign bus.repeating[1] = (state_q[1] == REPEAT);
endmodule

// File: doc/ball_step_gen.md
BALL_STEP_GEN -- requirements
Module: ball_step_gen

Interface
REQ-001 The block SHALL have parameter SIMULATE, default 0; when 1, the sim timing values in REQ-003/REQ-004 apply.
REQ-002 The block SHALL have parameter DELAY_CYCLES, default 50_000_000 (500 ms at 100 MHz); this is the hold time before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 20_000_000 (200 ms); this is the auto-repeat interval.
REQ-004 With SIMULATE=1, the block SHALL use effective delay 10 and repeat 4 in place of DELAY_CYCLES and REPEAT_CYCLES.
REQ-005 The block SHALL have port clk, input, 1 bit, the 100 MHz system clock; the block uses one clock only.
REQ-006 The block SHALL have port reset, input, 1 bit, a synchronous active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit; when high, stepping is allowed.
REQ-008 The block SHALL have port btn_xinc, input, 1 bit, the debounced level request for x+.
REQ-009 The block SHALL have port btn_xdec, input, 1 bit, the debounced level request for x-.
REQ-010 The block SHALL have port btn_yinc, input, 1 bit, the debounced level request for y+.
REQ-011 The block SHALL have port btn_ydec, input, 1 bit, the debounced level request for y-.
REQ-012 The block SHALL have port x_increment, output, 1 bit; a one-cycle pulse means step x+.
REQ-013 The block SHALL have port x_decrement, output, 1 bit; a one-cycle pulse means step x-.
REQ-014 The block SHALL have port y_increment, output, 1 bit; a one-cycle pulse means step y+.
REQ-015 The block SHALL have port y_decrement, output, 1 bit; a one-cycle pulse means step y-.
REQ-016 The block SHALL have port repeating, output, 2 bits: bit0 = x axis in REPEAT, bit1 = y axis in REPEAT.

Function
REQ-017 The block SHALL implement two identical, independent axis FSMs (x, y), each with states IDLE, DELAY and REPEAT and its own 26-bit down-counter.
REQ-018 Per axis, "request" SHALL be true when exactly one of inc/dec is high and enable is high; the requested direction is the one that is high.
REQ-019 IDLE with request sampled at edge N: the matching pulse SHALL be high for the one cycle after edge N; counter loaded with delay-1; next state DELAY.
REQ-020 DELAY: the counter SHALL decrement each cycle while the request is unchanged; at counter 0, the pulse SHALL be emitted, the counter loaded with repeat-1, and the next state is REPEAT.
REQ-021 REPEAT: at counter 0, the pulse SHALL be emitted and the counter reloaded with repeat-1; pulses therefore occur at edges N, N+delay, N+delay+k*repeat.
REQ-022 Loss of request in DELAY/REPEAT (release, both pressed, or enable low) SHALL return the FSM to IDLE on the next edge with no pulse and the counter cleared.
REQ-023 A direction reversal in one cycle (inc→dec while held) SHALL be treated as a new press: a pulse in the new direction next cycle, the counter reloaded with delay-1, and the state DELAY.
REQ-024 Inc and dec of one axis SHALL never pulse in the same cycle; x and y pulses may coincide.
REQ-025 Enable rising while a button is held SHALL be treated as a new press (REQ-019).
REQ-026 Each output pulse SHALL be exactly 1 cycle wide, registered, with no combinational path from any input to any output.
REQ-027 repeating[i] SHALL be high iff axis i is in REPEAT.

Reset
REQ-028 With reset low at an edge, both FSMs SHALL go to IDLE, counters to 0, and all pulse outputs and repeating to 0 by the next cycle, including during DELAY/REPEAT.
REQ-029 A button held through reset release SHALL be treated as a new press on the first edge with reset high.

Verification (SIMULATE=1: delay 10, repeat 4)
REQ-030 btn_xinc rises at edge 0 and is held 30 cycles → x_increment high after edges 0, 10, 14, 18, 22, 26, and no other output pulses.
REQ-031 btn_ydec held 5 cycles → exactly one y_decrement pulse (after edge 0); repeating stays 00.
REQ-032 btn_xinc and btn_xdec both high → no x pulses; drop btn_xdec at edge 7 → x_increment pulse after edge 7, next pulse after edge 17.
REQ-033 btn_xinc held to edge 12 (REPEAT), then switched to btn_xdec at edge 13 → x_decrement pulse after edge 13, next pulse after edge 23; repeating[0] 1→0.
REQ-034 Reset low at edge 12 while xinc/yinc held → all outputs 0; reset high at edge 14 → both axes pulse after edge 14, then at edge 24.
REQ-035 enable low at edge 5 with btn_yinc held, then high at edge 9 → no pulses during edges 5-9; pulse after edge 9, next after edge 19.
